// File: rtl/sm83_pkg.sv
// Shared types for the nibble-serial SM83 ALU: op codes, flag word, sequencer states,
// and the DAA correction helper.
package sm83_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBC = 4'd3,
    OP_AND = 4'd4,
    OP_XOR = 4'd5,
    OP_OR  = 4'd6,
    OP_CP  = 4'd7,
    OP_DAA = 4'd8
  } alu_op_t;

  typedef struct packed {
    logic f_z;
    logic f_n;
    logic f_h;
    logic f_c;
  } flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // BCD adjust amount; applied as an add when N=0 and as a subtract when N=1.
  function automatic logic [7:0] daa_corr(input logic [7:0] a, input flags_t f);
    daa_corr = 8'h00;
    if (f.f_h || (!f.f_n && a[3:0] > 4'h9)) daa_corr[3:0] = 4'h6;
    if (f.f_c || (!f.f_n && a > 8'h99))     daa_corr[7:4] = 4'h6;
  endfunction

endpackage

// File: rtl/sm83_serial_alu_if.sv
// Start/done request bus of the serial ALU; master drives operands, slave returns result.
interface sm83_serial_alu_if #(parameter int WIDTH = 8);
  import sm83_pkg::*;

  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] arg;
  flags_t           f_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  flags_t           f_out;

  modport master (output start, op, acc, arg, f_in,
                  input  busy, done, res, f_out);
  modport slave  (input  start, op, acc, arg, f_in,
                  output busy, done, res, f_out);
endinterface

// File: rtl/sm83_serial_alu_slice.sv
// One 4-bit ALU slice, combinational; shared by every nibble of the serial operation.
module sm83_alu_slice
  import sm83_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  alu_op_t    op_i,
  input  logic       c_i,
  output logic [3:0] r_o,
  output logic       c_o
);

  logic [4:0] sum;

  always_comb begin
    sum = 5'd0;
    r_o = a_i;
    c_o = 1'b0;
    case (op_i)
      OP_ADD, OP_ADC: begin
        sum        = {1'b0, a_i} + {1'b0, b_i} + {4'd0, c_i};
        {c_o, r_o} = sum;
      end
      // Subtract as a + ~b + c; caller inverts the carry into a borrow.
      OP_SUB, OP_SBC, OP_CP: begin
        sum        = {1'b0, a_i} + {1'b0, ~b_i} + {4'd0, c_i};
        {c_o, r_o} = sum;
      end
      OP_AND:  r_o = a_i & b_i;
      OP_XOR:  r_o = a_i ^ b_i;
      OP_OR:   r_o = a_i | b_i;
      default: r_o = a_i;
    endcase
  end

endmodule

// File: rtl/sm83_serial_alu.sv
// Nibble-serial SM83 ALU, LS slice first, latency WIDTH/4+1 cycles.
// Optional DAA support is enabled by defining SM83_ALU_DAA_EN.
module sm83_serial_alu
  import sm83_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit Z_PASS = 1'b0
) (
  input logic               clk,
  input logic               rst,
  sm83_serial_alu_if.slave  bus
);

  localparam int NS = WIDTH / 4;

  state_t           state_q, state_d;
  logic [1:0]       k_q, k_d;
  alu_op_t          op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d, arg_q, arg_d;
  flags_t           fin_q, fin_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] wrk_q, wrk_d, res_q, res_d;
  flags_t           fout_q, fout_d;

  logic             accept;
  logic [3:0]       sl_a, sl_b, sl_r;
  logic             sl_c;
  alu_op_t          sl_op;
  logic [WIDTH-1:0] full;
  logic             zc, zar, hc;

  assign accept = bus.start && (state_q != ST_RUN);
  assign sl_a   = 4'(acc_q >> {k_q, 2'b00});
  assign sl_b   = 4'(arg_q >> {k_q, 2'b00});
  assign full   = wrk_q | (WIDTH'(sl_r) << {k_q, 2'b00});
  assign zc     = ~|full;
  assign zar    = Z_PASS ? fin_q.f_z : zc;
  // Carry entering the top slice is the carry out of bit WIDTH-5.
  assign hc     = cy_q;

`ifdef SM83_ALU_DAA_EN
  logic daa_c_q;

  always_ff @(posedge clk) begin
    if (rst)         daa_c_q <= 1'b0;
    else if (accept) daa_c_q <= bus.f_in.f_c | (!bus.f_in.f_n && (bus.acc > WIDTH'(8'h99)));
  end
`endif

  always_comb begin
    sl_op = op_q;
`ifdef SM83_ALU_DAA_EN
    if (op_q == OP_DAA && WIDTH == 8) sl_op = fin_q.f_n ? OP_SUB : OP_ADD;
`endif
  end

  sm83_alu_slice u_slice (
    .a_i  (sl_a),
    .b_i  (sl_b),
    .op_i (sl_op),
    .c_i  (cy_q),
    .r_o  (sl_r),
    .c_o  (sl_c)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    op_d    = op_q;
    acc_d   = acc_q;
    arg_d   = arg_q;
    fin_d   = fin_q;
    cy_d    = cy_q;
    wrk_d   = wrk_q;
    res_d   = res_q;
    fout_d  = fout_q;
    case (state_q)
      ST_RUN: begin
        cy_d  = sl_c;
        wrk_d = full;
        if (k_q == 2'(NS - 1)) begin
          state_d = ST_DONE;
          res_d   = full;
          case (op_q)
            OP_ADD, OP_ADC: fout_d = {zar, 1'b0, hc, sl_c};
            OP_SUB, OP_SBC: fout_d = {zar, 1'b1, ~hc, ~sl_c};
            OP_CP: begin
              res_d  = acc_q;
              fout_d = {zar, 1'b1, ~hc, ~sl_c};
            end
            OP_AND:        fout_d = {zc, 1'b0, 1'b1, 1'b0};
            OP_XOR, OP_OR: fout_d = {zc, 1'b0, 1'b0, 1'b0};
`ifdef SM83_ALU_DAA_EN
            OP_DAA: begin
              if (WIDTH == 8) begin
                fout_d = {zc, fin_q.f_n, 1'b0, daa_c_q};
              end else begin
                res_d  = acc_q;
                fout_d = fin_q;
              end
            end
`endif
            default: begin
              res_d  = acc_q;
              fout_d = fin_q;
            end
          endcase
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      default: begin
        if (state_q == ST_DONE) state_d = ST_IDLE;
        if (bus.start) begin
          state_d = ST_RUN;
          op_d    = alu_op_t'(bus.op);
          acc_d   = bus.acc;
          arg_d   = bus.arg;
          fin_d   = bus.f_in;
          k_d     = 2'd0;
          wrk_d   = '0;
          // Slice 0 carry-in: C for ADC, 1 for SUB/CP, ~C for SBC.
          case (alu_op_t'(bus.op))
            OP_ADC:        cy_d = bus.f_in.f_c;
            OP_SUB, OP_CP: cy_d = 1'b1;
            OP_SBC:        cy_d = ~bus.f_in.f_c;
            default:       cy_d = 1'b0;
          endcase
`ifdef SM83_ALU_DAA_EN
          if (alu_op_t'(bus.op) == OP_DAA && WIDTH == 8) begin
            arg_d = WIDTH'(daa_corr(8'(bus.acc), bus.f_in));
            cy_d  = bus.f_in.f_n;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= 2'd0;
      op_q    <= OP_ADD;
      acc_q   <= '0;
      arg_q   <= '0;
      fin_q   <= '0;
      cy_q    <= 1'b0;
      wrk_q   <= '0;
      res_q   <= '0;
      fout_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      arg_q   <= arg_d;
      fin_q   <= fin_d;
      cy_q    <= cy_d;
      wrk_q   <= wrk_d;
      res_q   <= res_d;
      fout_q  <= fout_d;
    end
  end

  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.res   = res_q;
  assign bus.f_out = fout_q;

endmodule

// File: tb/tb_sm83_serial_alu.sv
// Bench for sm83_serial_alu: WIDTH=8 and WIDTH=16/Z_PASS instances against an integer model.
module tb_sm83_serial_alu;
  import sm83_pkg::*;

`ifdef SM83_ALU_DAA_EN
  localparam bit DAA_EN = 1'b1;
`else
  localparam bit DAA_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sm83_serial_alu_if #(.WIDTH(8))  b8 ();
  sm83_serial_alu_if #(.WIDTH(16)) b16 ();

  sm83_serial_alu #(.WIDTH(8),  .Z_PASS(1'b0)) u8  (.clk(clk), .rst(rst), .bus(b8));
  sm83_serial_alu #(.WIDTH(16), .Z_PASS(1'b1)) u16 (.clk(clk), .rst(rst), .bus(b16));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Whole-word reference: {Z,N,H,C, res}.
  function automatic logic [19:0] model(input int w, input bit zp, input int op,
                                        input int a, input int b, input logic [3:0] fin);
    int m, ml, r, s, cin, corr;
    bit z, n, h, c;
    m  = (1 << w) - 1;
    ml = (1 << (w - 4)) - 1;
    a  = a & m;
    b  = b & m;
    r  = a;
    {z, n, h, c} = fin;
    case (op)
      0, 1: begin
        cin = (op == 1 && fin[0]) ? 1 : 0;
        s = a + b + cin;
        r = s & m;
        c = s > m;
        h = ((a & ml) + (b & ml) + cin) > ml;
        n = 1'b0;
        z = zp ? fin[3] : (r == 0);
      end
      2, 3, 7: begin
        cin = (op == 3 && fin[0]) ? 1 : 0;
        s = a - b - cin;
        r = s & m;
        c = s < 0;
        h = ((a & ml) - (b & ml) - cin) < 0;
        n = 1'b1;
        z = zp ? fin[3] : (r == 0);
        if (op == 7) r = a;
      end
      4: begin r = a & b; {z, n, h, c} = {r == 0, 1'b0, 1'b1, 1'b0}; end
      5: begin r = a ^ b; {z, n, h, c} = {r == 0, 1'b0, 1'b0, 1'b0}; end
      6: begin r = a | b; {z, n, h, c} = {r == 0, 1'b0, 1'b0, 1'b0}; end
      8: begin
        if (DAA_EN && w == 8) begin
          corr = 0;
          if (fin[1] || (!fin[2] && (a & 15) > 9)) corr += 'h06;
          if (fin[0] || (!fin[2] && a > 'h99))     corr += 'h60;
          r = fin[2] ? ((a - corr) & m) : ((a + corr) & m);
          z = (r == 0);
          n = fin[2];
          h = 1'b0;
          c = fin[0] || (!fin[2] && a > 'h99);
        end
      end
      default: ;
    endcase
    return {z, n, h, c, 16'(r)};
  endfunction

  task automatic drive(input bit w16, input bit st, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b, input logic [3:0] fin);
    if (w16) begin
      b16.start = st; b16.op = op; b16.acc = a; b16.arg = b; b16.f_in = fin;
    end else begin
      b8.start = st; b8.op = op; b8.acc = a[7:0]; b8.arg = b[7:0]; b8.f_in = fin;
    end
  endtask

  task automatic sample(input bit w16, output bit dn, output bit bz,
                        output logic [15:0] r, output logic [3:0] f);
    if (w16) begin dn = b16.done; bz = b16.busy; r = b16.res; f = b16.f_out; end
    else     begin dn = b8.done;  bz = b8.busy;  r = {8'h00, b8.res}; f = b8.f_out; end
  endtask

  // One operation; ends at the negedge of the done cycle. now=1 issues start in the
  // current cycle, poke=1 re-asserts start with junk operands while the op is running.
  task automatic do_op(input bit w16, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] fin, input bit now,
                       input bit poke, output logic [15:0] ores, output logic [3:0] ofl);
    int w, ns, cyc, bcnt;
    logic [19:0] exp;
    bit dn, bz;
    w   = w16 ? 16 : 8;
    ns  = w / 4;
    exp = model(w, w16, int'(op), int'(a), int'(b), fin);
    if (!now) @(negedge clk);
    drive(w16, 1'b1, op, a, b, fin);
    @(negedge clk);
    if (poke) drive(w16, 1'b1, 4'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
    else      drive(w16, 1'b0, op, a, b, fin);
    cyc = 1;
    sample(w16, dn, bz, ores, ofl);
    bcnt = int'(bz);
    while (!dn && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) drive(w16, 1'b0, op, a, b, fin);
      sample(w16, dn, bz, ores, ofl);
      bcnt += int'(bz);
    end
    chk("done_seen", 32'(dn), 32'd1);
    chk("latency", cyc, ns + 1);
    chk("busy_cycles", bcnt, ns);
    chk("res", 32'(ores), 32'(exp[15:0]));
    chk("flags", 32'(ofl), 32'(exp[19:16]));
  endtask

  logic [15:0] r;
  logic [3:0]  f;

  initial begin
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0);
    drive(1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0);
    repeat (3) @(negedge clk);
    chk("rst_busy8", 32'(b8.busy), 0);
    chk("rst_done8", 32'(b8.done), 0);
    chk("rst_res8", 32'(b8.res), 0);
    chk("rst_f8", 32'(b8.f_out), 0);
    chk("rst_busy16", 32'(b16.busy), 0);
    chk("rst_res16", 32'(b16.res), 0);
    rst = 1'b0;

    do_op(1'b0, 4'd0, 16'h3A, 16'hC6, 4'b0000, 1'b0, 1'b0, r, f);
    chk("add_res", 32'(r), 32'h00);
    chk("add_fl", 32'(f), 32'b1011);
    @(negedge clk);
    chk("done_one_cycle", 32'(b8.done), 0);
    chk("res_hold", 32'(b8.res), 32'h00);

    do_op(1'b0, 4'd2, 16'h10, 16'h01, 4'b0000, 1'b0, 1'b0, r, f);
    chk("sub_res", 32'(r), 32'h0F);
    chk("sub_fl", 32'(f), 32'b0110);
    do_op(1'b0, 4'd3, 16'h00, 16'h00, 4'b0001, 1'b0, 1'b0, r, f);
    chk("sbc_res", 32'(r), 32'hFF);
    chk("sbc_fl", 32'(f), 32'b0111);
    do_op(1'b0, 4'd7, 16'h42, 16'h42, 4'b0000, 1'b0, 1'b0, r, f);
    chk("cp_res", 32'(r), 32'h42);
    chk("cp_fl", 32'(f), 32'b1100);

    do_op(1'b1, 4'd0, 16'h0FFF, 16'h0001, 4'b1000, 1'b0, 1'b0, r, f);
    chk("add16_res", 32'(r), 32'h1000);
    chk("add16_fl", 32'(f), 32'b1010);

    do_op(1'b0, 4'd0, 16'h12, 16'h34, 4'b0000, 1'b0, 1'b1, r, f);
    chk("poke_res", 32'(r), 32'h46);

    do_op(1'b0, 4'd2, 16'h50, 16'h20, 4'b0000, 1'b0, 1'b0, r, f);
    do_op(1'b0, 4'd4, 16'hF0, 16'h3C, 4'b0000, 1'b1, 1'b0, r, f);
    chk("b2b_res", 32'(r), 32'h30);

    // Reset in the second RUN cycle: no done, outputs cleared next cycle.
    @(negedge clk);
    drive(1'b0, 1'b1, 4'd0, 16'h11, 16'h22, 4'b0000);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 16'h11, 16'h22, 4'b0000);
    @(negedge clk);
    chk("abort_busy_run", 32'(b8.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_done", 32'(b8.done), 0);
    chk("abort_busy", 32'(b8.busy), 0);
    chk("abort_res", 32'(b8.res), 0);
    chk("abort_f", 32'(b8.f_out), 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 32'(b8.done), 0);
    end
    do_op(1'b0, 4'd4, 16'hF0, 16'h3C, 4'b0000, 1'b0, 1'b0, r, f);
    chk("and_res", 32'(r), 32'h30);
    chk("and_fl", 32'(f), 32'b0010);

    do_op(1'b0, 4'd8, 16'h9A, 16'h00, 4'b0000, 1'b0, 1'b0, r, f);
    chk("daa_res", 32'(r), DAA_EN ? 32'h00 : 32'h9A);
    chk("daa_fl", 32'(f), DAA_EN ? 32'b1001 : 32'b0000);

    repeat (60) begin
      bit w16;
      w16 = ($urandom_range(0, 3) == 0);
      do_op(w16, 4'($urandom_range(0, 11)), 16'($urandom), 16'($urandom), 4'($urandom),
            1'b0, 1'($urandom_range(0, 1)), r, f);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
